// File: rtl/shared_block_rotate_seq.sv
// rtl/shared_block_rotate_seq.sv - two-share block-wise rotator, STEP bits per BUSY cycle
// Optional feature macro: SHARE_REMASK_EN (adds remask input, XORed into both shares at accept)
module shared_block_rotate_seq #(
  parameter int DATA_W  = 64,
  parameter int BLOCK_W = 32,
  parameter int STEP    = 4,
  localparam int CNT_W  = $clog2(BLOCK_W / STEP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  rot_amt,
  input  logic              dir,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
`ifdef SHARE_REMASK_EN
  input  logic [DATA_W-1:0] remask,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout0,
  output logic [DATA_W-1:0] dout1,
  output logic              busy
);

  localparam int NBLK = DATA_W / BLOCK_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              dir_q;
  logic              accept;
  logic [DATA_W-1:0] cap0;
  logic [DATA_W-1:0] cap1;
  logic [DATA_W-1:0] rot0;
  logic [DATA_W-1:0] rot1;

  // Rotate every block of a share by STEP bits; blocks never exchange bits.
  function automatic logic [DATA_W-1:0] rot_share(input logic [DATA_W-1:0] s, input logic right);
    logic [DATA_W-1:0] r;
    logic [BLOCK_W-1:0] blk;
    r = '0;
    for (int b = 0; b < NBLK; b++) begin
      blk = s[b*BLOCK_W +: BLOCK_W];
      if (right)
        r[b*BLOCK_W +: BLOCK_W] = {blk[STEP-1:0], blk[BLOCK_W-1:STEP]};
      else
        r[b*BLOCK_W +: BLOCK_W] = {blk[BLOCK_W-STEP-1:0], blk[BLOCK_W-1:BLOCK_W-STEP]};
    end
    return r;
  endfunction

  assign accept = in_valid && (state == IDLE);
  assign rot0   = rot_share(dout0, dir_q);
  assign rot1   = rot_share(dout1, dir_q);

`ifdef SHARE_REMASK_EN
  // The same mask on both shares leaves their XOR (the secret) unchanged.
  assign cap0 = din0 ^ remask;
  assign cap1 = din1 ^ remask;
`else
  assign cap0 = din0;
  assign cap1 = din1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: a zero rotation skips BUSY, DONE waits for out_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (rot_amt == '0) ? DONE : BUSY;
      BUSY: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Share registers, step counter and direction: capture on accept, rotate while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      dir_q <= 1'b0;
      dout0 <= '0;
      dout1 <= '0;
    end else if (accept) begin
      cnt   <= rot_amt;
      dir_q <= dir;
      dout0 <= cap0;
      dout1 <= cap1;
    end else if (state == BUSY) begin
      cnt   <= cnt - CNT_W'(1);
      dout0 <= rot0;
      dout1 <= rot1;
    end
  end

endmodule

// File: tb/tb_shared_block_rotate_seq.sv
// tb/tb_shared_block_rotate_seq.sv - scoreboard bench for shared_block_rotate_seq
module tb_shared_block_rotate_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  rot_amt;
  logic        dir;
  logic [63:0] din0;
  logic [63:0] din1;
`ifdef SHARE_REMASK_EN
  logic [63:0] remask;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout0;
  logic [63:0] dout1;
  logic        busy;

  shared_block_rotate_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .rot_amt(rot_amt),
    .dir(dir),
    .din0(din0),
    .din1(din1),
`ifdef SHARE_REMASK_EN
    .remask(remask),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout0(dout0),
    .dout1(dout1),
    .busy(busy)
  );

  typedef struct {
    logic [63:0] e0;
    logic [63:0] e1;
    int          acc;
    int          n;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented result against the head of the queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        if (!prev_valid) chk("latency", 64'(cyc - q[0].acc), 64'(q[0].n + 1));
        chk("dout0", dout0, q[0].e0);
        chk("dout1", dout1, q[0].e1);
        if (out_ready) void'(q.pop_front());
      end
    end
    prev_valid = (out_valid === 1'b1);
  end

  // Drive one request (called just after a posedge); pushes the expectation when push=1.
  task automatic send(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] rm,
                      input int amt, input logic dr, input logic [63:0] e0,
                      input logic [63:0] e1, input bit push, output int tries);
    exp_t e;
    bit   ok;
    ok = 0;
    tries = 0;
    in_valid = 1'b1;
    din0 = d0;
    din1 = d1;
    rot_amt = 3'(amt);
    dir = dr;
`ifdef SHARE_REMASK_EN
    remask = rm;
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
      tries++;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else if (push) begin
      e.e0 = e0; e.e1 = e1; e.acc = cyc; e.n = amt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din0 = {$urandom, $urandom};
    din1 = {$urandom, $urandom};
    rot_amt = 3'($urandom);
    dir = 1'($urandom);
`ifdef SHARE_REMASK_EN
    remask = {$urandom, $urandom};
`endif
    if (rm == 64'hx) tries = tries;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tries;
    int bcnt;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rot_amt = '0;
    dir = 1'b0;
    din0 = '0;
    din1 = '0;
`ifdef SHARE_REMASK_EN
    remask = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dout0", dout0, 64'd0);
    chk("rst_dout1", dout1, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Left by one step, accepted on the first edge out of reset.
    send(64'h0123456789ABCDEF, 64'h0, 64'h0, 1, 1'b0,
         64'h123456709ABCDEF8, 64'h0, 1, tries);
    chk("first_accept_tries", 64'(tries), 64'd0);
    drain();

    // Right by two steps.
    send(64'h0123456789ABCDEF, 64'h0, 64'h0, 2, 1'b1,
         64'h67012345EF89ABCD, 64'h0, 1, tries);
    drain();

    // Zero rotation: result equals input, busy for a single cycle.
    send(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 64'h0, 0, 1'b0,
         64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 1, tries);
    bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
    end
    chk("zero_busy_cycles", 64'(bcnt), 64'd1);
    drain();

    // Maximum count, both directions, non-zero share 1.
    send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 7, 1'b0,
         64'h70123456F89ABCDE, 64'h8FEDCBA907654321, 1, tries);
    drain();
    send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 7, 1'b1,
         64'h123456709ABCDEF8, 64'hEDCBA98F65432107, 1, tries);
    drain();

    // Backpressure: held result, in_ready low, in_valid pulses ignored.
    out_ready = 1'b0;
    send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 1, 1'b1,
         64'h70123456F89ABCDE, 64'h8FEDCBA907654321, 1, tries);
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) break;
      @(negedge clk);
    end
    chk("bp_reached_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      din0 = {$urandom, $urandom};
      rot_amt = 3'($urandom);
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after", 64'(out_valid), 64'd0);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset during the third BUSY cycle aborts the operation.
    send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 7, 1'b0,
         64'h0, 64'h0, 0, tries);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_dout0", dout0, 64'd0);
    chk("abort_dout1", dout1, 64'd0);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;

    // Recovery after the abort: left by four steps.
    send(64'h0123456789ABCDEF, 64'h0, 64'h0, 4, 1'b0,
         64'h45670123CDEF89AB, 64'h0, 1, tries);
    drain();

`ifdef SHARE_REMASK_EN
    // Remask: shares change, their XOR is the rotated secret.
    send(64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'hA5A5A5A5A5A5A5A5, 3, 1'b0,
         64'hAA5A55A5AA5A55A5, 64'hAAAAAAAAAAAAAAAA, 1, tries);
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) break;
      @(negedge clk);
    end
    chk("remask_xor", dout0 ^ dout1, 64'h00F0FF0F00F0FF0F);
    n_checks++;
    if (dout0 === 64'hF0000FFFF0000FFF) begin
      n_fail++;
      $display("FAIL remask_differs: got %h expected not %h", dout0, 64'hF0000FFFF0000FFF);
    end
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
